// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiply-accumulate path: product width
// default and the accumulator control state encoding.
package vedic_pkg;

  localparam int PROD_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_sat_add.sv
// Combinational unsigned saturating adder: ACC_W-bit accumulator plus a
// zero-extended PROD_W-bit product, clipped to all-ones on carry out.
module vedic_sat_add #(
  parameter int ACC_W  = 16,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] wide);
    return wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  endfunction

  logic [ACC_W:0] wide;

  assign wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign sat  = wide[ACC_W];
  assign sum  = sat_clip(wide);

endmodule

// File: rtl/vedic_prod_accumulator.sv
// Frame accumulator behind the 4x4 Vedic multiplier: sums frame_len products
// with saturation and presents the sum plus a sticky overflow flag.
module vedic_prod_accumulator
  import vedic_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  frame_len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;
  logic               beat;

  vedic_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc  (acc),
    .prod (prod_data),
    .sum  (add_sum),
    .sat  (add_sat)
  );

  assign beat = (state == ST_ACCUM) && prod_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (frame_len != '0) ? ST_ACCUM : ST_HOLD;
      end
      ST_ACCUM: begin
        if (prod_valid && (cnt == CNT_W'(1))) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= frame_len;
      end else if (beat) begin
        // Saturation keeps acc at all-ones for the rest of the frame since
        // every further addend is non-negative.
        acc <= add_sum;
        ovf <= ovf | add_sat;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign prod_ready = (state == ST_ACCUM);
  assign out_valid  = (state == ST_HOLD);
  assign busy       = (state != ST_IDLE);
  assign out_data   = acc;
  assign out_ovf    = ovf;

endmodule

// File: tb/tb_vedic_prod_accumulator.sv
// Bench for vedic_prod_accumulator: a 16-bit and a 10-bit accumulator share
// random frame stimulus and are checked against an arithmetic frame-sum model.
module tb_vedic_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  frame_len;
  logic        prod_valid;
  logic [7:0]  prod_data;
  logic        out_ready;

  logic        prod_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [15:0] out_data_a;
  logic        prod_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [9:0]  out_data_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint d16;
    bit     o16;
    longint d10;
    bit     o10;
  } exp_t;

  exp_t expq[$];

  vedic_prod_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready_a),
    .out_valid  (out_valid_a),
    .out_data   (out_data_a),
    .out_ovf    (out_ovf_a),
    .out_ready  (out_ready),
    .busy       (busy_a)
  );

  vedic_prod_accumulator #(.PROD_W(8), .ACC_W(10), .CNT_W(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready_b),
    .out_valid  (out_valid_b),
    .out_data   (out_data_b),
    .out_ovf    (out_ovf_b),
    .out_ready  (out_ready),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Frame result model: plain sum of the products, clipped to the width.
  function automatic longint model_sum(input int p[$]);
    longint s = 0;
    foreach (p[i]) s += p[i];
    return s;
  endfunction

  function automatic longint sat_to(input longint s, input int w);
    longint m = (longint'(1) << w) - 1;
    return (s > m) ? m : s;
  endfunction

  function automatic exp_t model_frame(input int p[$]);
    exp_t e;
    longint s = model_sum(p);
    e.d16 = sat_to(s, 16);
    e.o16 = (s > 65535);
    e.d10 = sat_to(s, 10);
    e.o10 = (s > 1023);
    return e;
  endfunction

  // Result comparison on the falling edge whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && (out_valid_a || out_valid_b)) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid_a | out_valid_b), 0);
      end else begin
        chk("out_valid_a", 64'(out_valid_a), 1);
        chk("out_valid_b", 64'(out_valid_b), 1);
        chk("out_data_16", 64'(out_data_a), 64'(expq[0].d16));
        chk("out_ovf_16",  64'(out_ovf_a),  64'(expq[0].o16));
        chk("out_data_10", 64'(out_data_b), 64'(expq[0].d10));
        chk("out_ovf_10",  64'(out_ovf_b),  64'(expq[0].o10));
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_prod_ready"}, 64'({prod_ready_a, prod_ready_b}), 0);
    chk({tag, "_out_valid"},  64'({out_valid_a, out_valid_b}), 0);
    chk({tag, "_busy"},       64'({busy_a, busy_b}), 0);
    chk({tag, "_out_data_16"}, 64'(out_data_a), 0);
    chk({tag, "_out_data_10"}, 64'(out_data_b), 0);
    chk({tag, "_out_ovf"},    64'({out_ovf_a, out_ovf_b}), 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  // One complete frame: start, products with optional gaps, result hold,
  // and optional start pulses that must be ignored outside IDLE.
  task automatic run_frame(input int p[$], input int gap_max, input int hold, input bit noise);
    int len = p.size();
    int g;
    @(posedge clk); #1;
    chk("idle_before_start", 64'(busy_a), 0);
    start = 1'b1;
    frame_len = 4'(len);
    if (len == 0) expq.push_back(model_frame(p));
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = 4'($urandom);
    chk("busy_after_start", 64'(busy_a), 1);
    for (int i = 0; i < len; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        if (noise) start = 1'($urandom_range(0, 1));
        prod_data = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("prod_ready_accum", 64'(prod_ready_a), 1);
      prod_valid = 1'b1;
      prod_data  = 8'(p[i]);
      if (noise) start = 1'($urandom_range(0, 1));
      if (i == len - 1) expq.push_back(model_frame(p));
      @(posedge clk); #1;
      prod_valid = 1'b0;
      start = 1'b0;
      prod_data = 8'($urandom);
    end
    chk("latency_out_valid", 64'(out_valid_a), 1);
    chk("hold_prod_ready", 64'(prod_ready_a), 0);
    repeat (hold) begin
      if (noise) start = 1'b1;
      prod_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      prod_valid = 1'b0;
      chk("hold_out_valid", 64'(out_valid_a), 1);
      chk("hold_prod_ready", 64'(prod_ready_a), 0);
    end
    out_ready = 1'b1;
    start = noise;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("exit_out_valid", 64'(out_valid_a), 0);
    chk("exit_busy", 64'(busy_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p[$];
    exp_t e;
    rst = 1'b1; start = 1'b0; frame_len = '0; prod_valid = 1'b0;
    prod_data = '0; out_ready = 1'b0;

    // Pin the model against hand-computed results.
    p = '{6, 20, 225, 0};
    e = model_frame(p);
    chk("model_251", 64'(e.d16), 251);
    p = '{225, 225, 225, 225, 225};
    e = model_frame(p);
    chk("model_sat10", 64'(e.d10), 1023);
    chk("model_ovf10", 64'(e.o10), 1);
    p = {};
    for (int i = 0; i < 15; i++) p.push_back(225);
    e = model_frame(p);
    chk("model_3375", 64'(e.d16), 3375);

    do_reset(2);

    // Reset in the middle of a frame aborts it without a result.
    @(posedge clk); #1;
    start = 1'b1; frame_len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    prod_valid = 1'b1; prod_data = 8'd100;
    repeat (2) @(posedge clk);
    #1;
    prod_valid = 1'b0;
    chk("mid_frame_busy", 64'(busy_a), 1);
    do_reset(2);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_no_result", 64'(out_valid_a), 0);

    p = '{6, 20, 225, 0};
    run_frame(p, 0, 0, 0);
    chk("direct_251", 64'(out_data_a), 251);
    run_frame(p, 3, 5, 1);

    p = '{225, 225, 225, 225, 225};
    run_frame(p, 0, 1, 0);
    chk("direct_1023", 64'(out_data_b), 1023);
    chk("direct_ovf10", 64'(out_ovf_b), 1);

    p = {};
    run_frame(p, 0, 0, 1);
    chk("direct_len0", 64'(out_data_a), 0);

    p = {};
    for (int i = 0; i < 15; i++) p.push_back(225);
    run_frame(p, 1, 2, 1);
    chk("direct_3375", 64'(out_data_a), 3375);

    for (int f = 0; f < 25; f++) begin
      int n = int'($urandom_range(0, 15));
      p = {};
      for (int i = 0; i < n; i++) p.push_back(int'($urandom_range(0, 255)));
      run_frame(p, 3, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    chk("queue_drained", 64'(expq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
